// File: rtl/lfsr32_if.sv
// lfsr32_if: control/data bundle for the lfsr32 pseudo-random word generator.
//   init  master->slave  synchronous seed load request (wins over go)
//   go    master->slave  advance one step this cycle
//   seed  master->slave  N-bit value loaded when init=1
//   q     slave->master  current register contents (registered)
interface lfsr32_if #(
   parameter int N = 32
);
   logic         init;
   logic         go;
   logic [N-1:0] seed;
   logic [N-1:0] q;

   modport master (output init, output go, output seed, input q);
   modport slave  (input init, input go, input seed, output q);
endinterface

// File: rtl/lfsr32.sv
// lfsr32: N-bit Fibonacci LFSR. A seed is loaded with init; each cycle go is
// high the register shifts right by one with the tap parity entering the MSB.
// With neither request the value is held. The all-zero state locks up until
// re-seeded.
//   clk   in   clock, rising edge
//   rst   in   asynchronous active-high reset, forces q to RST_VAL
//   bus   slave modport of lfsr32_if (init, go, seed in; q out)
module lfsr32 #(
   parameter int           N       = 32,
   parameter logic [N-1:0] TAPS    = 32'hC000_0401,
   parameter logic [N-1:0] RST_VAL = 32'h0000_0001
) (
   input  logic     clk,
   input  logic     rst,
   lfsr32_if.slave  bus
);

   logic [N-1:0] q_q;
   logic [N-1:0] q_d;
   logic         fb;

   // Feedback is the parity of the tapped bits of the current state.
   assign fb = ^(q_q & TAPS);

   always_comb begin
      q_d = q_q;
      if (bus.init) begin
         q_d = bus.seed;
      end else if (bus.go) begin
         q_d = {fb, q_q[N-1:1]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q_q <= RST_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign bus.q = q_q;

endmodule

// File: tb/tb_lfsr32.sv
module tb_lfsr32;

   localparam logic [31:0] TAPS    = 32'hC000_0401;
   localparam logic [31:0] RST_VAL = 32'h0000_0001;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;
   logic [31:0] m_q;

   lfsr32_if #(.N(32)) bus ();

   lfsr32 #(.N(32), .TAPS(TAPS), .RST_VAL(RST_VAL)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference step: count the tapped bits that are set; an odd count puts a 1
   // into the top bit after a plain divide-by-two of the state.
   function automatic logic [31:0] ref_step(input logic [31:0] s);
      int ones;
      ones = 0;
      for (int i = 0; i < 32; i++) begin
         if (TAPS[i] && s[i]) ones++;
      end
      return (s / 2) + ((ones % 2 == 1) ? 32'h8000_0000 : 32'h0);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model of the register contents.
   always @(posedge clk or posedge rst) begin
      if (rst)               m_q <= RST_VAL;
      else if (bus.init)     m_q <= bus.seed;
      else if (bus.go)       m_q <= ref_step(m_q);
   end

   // Every cycle, away from the rising edge, DUT must agree with the model.
   always @(negedge clk) begin
      check("model", bus.q, m_q);
   end

   // Inputs change 1 time unit after the falling edge, so the next rising
   // edge samples them cleanly.
   task automatic apply(input logic i, input logic g, input logic [31:0] s);
      @(negedge clk);
      #1;
      bus.init = i;
      bus.go   = g;
      bus.seed = s;
   endtask

   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic load_and_check(input string name, input logic [31:0] s);
      apply(1'b1, 1'b0, s);
      after_edge();
      check(name, bus.q, s);
   endtask

   initial begin
      logic [31:0] s;
      n_cmp    = 0;
      n_bad    = 0;
      rst      = 1'b1;
      bus.init = 1'b0;
      bus.go   = 1'b0;
      bus.seed = 32'h0;

      // Reset value, including across rising edges with reset held.
      #2;
      check("reset_value", bus.q, 32'h0000_0001);
      repeat (2) @(posedge clk);
      #1;
      check("reset_held", bus.q, 32'h0000_0001);
      @(negedge clk);
      #1;
      rst = 1'b0;

      // Seed loads.
      load_and_check("init_12345678", 32'h1234_5678);
      load_and_check("init_zero", 32'h0000_0000);
      load_and_check("init_9abcdef0", 32'h9ABC_DEF0);
      s = $urandom;
      load_and_check("init_random", s);

      // Storage: hold with seed wiggling while init=0.
      load_and_check("store_load", 32'h5566_7788);
      for (int k = 0; k < 3; k++) begin
         apply(1'b0, 1'b0, $urandom);
         after_edge();
         check("store_hold", bus.q, 32'h5566_7788);
      end

      // Single steps with hand-computed results.
      load_and_check("gen_load_a", 32'h1234_5678);
      apply(1'b0, 1'b1, 32'h0);
      after_edge();
      check("gen_step_a", bus.q, 32'h891A_2B3C);
      load_and_check("gen_load_b", 32'h0000_0001);
      apply(1'b0, 1'b1, 32'h0);
      after_edge();
      check("gen_step_b", bus.q, 32'h8000_0000);

      // Even seeds: low bits after one step are the old upper bits.
      for (int k = 0; k < 6; k++) begin
         s = $urandom & 32'hFFFF_FFFE;
         load_and_check("even_load", s);
         apply(1'b0, 1'b1, $urandom);
         after_edge();
         check("even_shift", (bus.q << 1) & 32'hFFFF_FFFE, s);
      end

      // init beats go in the same cycle.
      load_and_check("prio_pre", 32'h0F0F_0F0F);
      apply(1'b1, 1'b1, 32'hA5A5_A5A5);
      after_edge();
      check("prio_init_wins", bus.q, 32'hA5A5_A5A5);

      // Lockup state.
      load_and_check("lock_load", 32'h0);
      for (int k = 0; k < 3; k++) begin
         apply(1'b0, 1'b1, 32'h0);
         after_edge();
         check("lock_zero", bus.q, 32'h0);
      end

      // Multi-step run from 1 with go held high; the model compares every cycle.
      load_and_check("multi_load", 32'h0000_0001);
      apply(1'b0, 1'b1, 32'h0);
      repeat (31) after_edge();
      after_edge();
      apply(1'b0, 1'b0, 32'h0);

      // Random traffic.
      for (int k = 0; k < 300; k++) begin
         apply(($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1, $urandom);
      end
      apply(1'b0, 1'b0, 32'h0);

      // Asynchronous reset in mid-cycle.
      load_and_check("arst_load", 32'h1234_5678);
      apply(1'b0, 1'b1, 32'h0);
      after_edge();
      check("arst_pre", bus.q, 32'h891A_2B3C);
      bus.go = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      check("arst_immediate", bus.q, 32'h0000_0001);
      after_edge();
      check("arst_hold", bus.q, 32'h0000_0001);
      @(negedge clk);
      #1;
      rst = 1'b0;
      apply(1'b0, 1'b1, 32'h0);
      after_edge();
      check("arst_first_step", bus.q, 32'h8000_0000);
      apply(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
